// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encodings and helpers for the HD44780
// character-LCD driver (lcd_ctrl and its write sequencer lcd_write_seq).
//
// Build option:
//   LCD_CTRL_CURSOR_EN  when defined, the display-control command written during
//                       initialisation turns the cursor and blink on (0x0F);
//                       otherwise the display is on with cursor and blink off (0x0C).
package lcd_pkg;

  // HD44780 commands used by this driver
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38; // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON       = 8'h0C; // display on, cursor off, blink off
  localparam logic [7:0] DISP_ON_CUR   = 8'h0F; // display on, cursor on, blink on
  localparam logic [7:0] CLEAR         = 8'h01; // clear display (long execution time)
  localparam logic [7:0] ENTRY_INC     = 8'h06; // increment address, no shift
  localparam logic [7:0] DDRAM_L1      = 8'h80; // DDRAM address 0x00 (line 1)
  localparam logic [7:0] DDRAM_L2      = 8'hC0; // DDRAM address 0x40 (line 2)

`ifdef LCD_CTRL_CURSOR_EN
  localparam logic [7:0] DISP_CTRL = DISP_ON_CUR;
`else
  localparam logic [7:0] DISP_CTRL = DISP_ON;
`endif

  // Number of commands in the power-up initialisation sequence
  localparam int unsigned INIT_LEN = 6;

  // Top FSM state encoding
  typedef logic [2:0] top_state_t;
  localparam top_state_t ST_POWERUP   = 3'd0;
  localparam top_state_t ST_INIT      = 3'd1;
  localparam top_state_t ST_LINE_ADDR = 3'd2;
  localparam top_state_t ST_FETCH     = 3'd3;
  localparam top_state_t ST_CHAR      = 3'd4;
  localparam top_state_t ST_FRAME_END = 3'd5;

  // Write-sequencer state encoding
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WS_IDLE   = 2'd0;
  localparam wr_state_t WS_SETUP  = 2'd1;
  localparam wr_state_t WS_E_HIGH = 2'd2;
  localparam wr_state_t WS_WAIT   = 2'd3;

  // Observability bundle exported by the top level
  typedef struct packed {
    top_state_t top_state;
    wr_state_t  wr_state;
    logic [2:0] init_idx;
    logic [4:0] pos;
    logic [7:0] data;
  } lcd_dbg_t;

  // Counter width able to hold 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 2);
  endfunction

  // Command issued at a given step of the initialisation sequence
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd3:    cmd = DISP_CTRL;
      3'd4:    cmd = CLEAR;
      3'd5:    cmd = ENTRY_INC;
      default: cmd = FUNC_SET_8B2L;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_write_seq.sv
// lcd_write_seq: one timed HD44780 write transaction.
// A transaction drives RS/DB for SETUP_CYC cycles with E low, raises E for
// max(E_HIGH_CYC,1) cycles, then holds E low for the post-E wait (CMD_WAIT_CYC,
// or CLEAR_WAIT_CYC when long_wait_i was set at start). RS/DB only change when
// a transaction is started.
//
// Handshake: start_i is a single-cycle request carrying rs_i/data_i/long_wait_i.
// It is accepted when the sequencer is idle or in the cycle done_o is high, so a
// back-to-back request issued in the done cycle starts with no idle gap. done_o
// is high during the last cycle of a transaction.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, rs_i, data_i,  transaction request and its payload
//   long_wait_i
//   lcd_e_o, lcd_rs_o,      registered panel strobe / register select / data
//   lcd_db_o
//   done_o                  last cycle of the current transaction
//   state_o                 current sequencer state (debug)
module lcd_write_seq
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_db_o,
  output logic       done_o,
  output wr_state_t  state_o
);

  localparam int unsigned EH    = (E_HIGH_CYC == 0) ? 1 : E_HIGH_CYC;
  localparam int unsigned MAX_A = (SETUP_CYC > EH) ? SETUP_CYC : EH;
  localparam int unsigned MAX_B = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = cnt_width(MAXC);

  // Terminal counts; a zero-length phase is skipped so its value is never used
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EH_LAST    = CW'(EH - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

  wr_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic          long_q, long_d;
  logic          e_q;
  logic [CW-1:0] wait_last;
  logic          wait_zero;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    db_d      = db_q;
    long_d    = long_q;
    done_o    = 1'b0;
    wait_last = long_q ? CLEAR_LAST : CMD_LAST;
    wait_zero = long_q ? (CLEAR_WAIT_CYC == 0) : (CMD_WAIT_CYC == 0);

    case (state_q)
      WS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = WS_E_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WS_E_HIGH: begin
        if (cnt_q == EH_LAST) begin
          cnt_d = '0;
          if (wait_zero) begin
            done_o  = 1'b1;
            state_d = WS_IDLE;
          end else begin
            state_d = WS_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WS_WAIT: begin
        if (cnt_q == wait_last) begin
          done_o  = 1'b1;
          state_d = WS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A new request overrides the return to idle
    if (start_i) begin
      rs_d    = rs_i;
      db_d    = data_i;
      long_d  = long_wait_i;
      cnt_d   = '0;
      state_d = (SETUP_CYC == 0) ? WS_E_HIGH : WS_SETUP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WS_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      long_q  <= long_d;
      // E is a flop so the panel never sees decode glitches
      e_q     <= (state_d == WS_E_HIGH);
    end
  end

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_db_o = db_q;
  assign state_o  = state_q;

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 character-LCD driver fed from a 32-character buffer memory.
// After POWERUP_CYC idle cycles it writes the initialisation sequence, then
// refreshes the panel forever: 0x80, characters 0-15, 0xC0, characters 16-31,
// one FRAME_DONE pulse, repeat. Each character is fetched by driving ADDR and
// capturing lcd_bus at the end of the second fetch cycle.
//
// Build option: LCD_CTRL_CURSOR_EN selects the cursor/blink-on display-control
// command (see lcd_pkg).
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   ADDR            registered character index into the buffer memory
//   lcd_bus         byte returned by the buffer memory
//   LCD_DB, LCD_RS, LCD_RW, LCD_E   panel bus (RW is tied low)
//   READY           high once initialisation has completed
//   FRAME_DONE      one-cycle pulse after the 32nd character of a frame
//   dbg_o           internal state bundle (debug)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [4:0] ADDR,
  input  logic [7:0] lcd_bus,
  output logic [7:0] LCD_DB,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       READY,
  output logic       FRAME_DONE,
  output lcd_dbg_t   dbg_o
);

  localparam int unsigned   PW        = cnt_width(POWERUP_CYC);
  localparam logic [PW-1:0] PU_LAST   = PW'(POWERUP_CYC - 1);
  localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN - 1);

  top_state_t    state_q, state_d;
  logic [PW-1:0] pu_cnt_q, pu_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    pos_q, pos_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          fetch_ph_q, fetch_ph_d;
  logic          ready_q, ready_d;
  logic          frame_done_q, frame_done_d;

  logic          wr_start, wr_rs, wr_long, wr_done;
  logic [7:0]    wr_data;
  logic [2:0]    next_idx;
  logic [4:0]    pos_inc;
  logic          pu_done;
  wr_state_t     wr_state;

  assign next_idx = idx_q + 3'd1;
  assign pos_inc  = pos_q + 5'd1;
  assign pu_done  = (POWERUP_CYC == 0) || (pu_cnt_q == PU_LAST);

  // Every transition into a write issues the request in the same cycle, so the
  // next transaction starts right after the previous one's wait ends.
  always_comb begin
    state_d      = state_q;
    pu_cnt_d     = pu_cnt_q;
    idx_d        = idx_q;
    pos_d        = pos_q;
    addr_d       = addr_q;
    data_d       = data_q;
    fetch_ph_d   = fetch_ph_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    wr_start     = 1'b0;
    wr_rs        = 1'b0;
    wr_long      = 1'b0;
    wr_data      = 8'h00;

    case (state_q)
      ST_POWERUP: begin
        if (pu_done) begin
          state_d  = ST_INIT;
          idx_d    = 3'd0;
          wr_start = 1'b1;
          wr_data  = init_cmd(3'd0);
          wr_long  = (wr_data == CLEAR);
        end else begin
          pu_cnt_d = pu_cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx_q == INIT_LAST) begin
            ready_d = 1'b1;
            state_d = ST_LINE_ADDR;
            wr_data = DDRAM_L1;
          end else begin
            idx_d   = next_idx;
            wr_data = init_cmd(next_idx);
            wr_long = (wr_data == CLEAR);
          end
        end
      end
      ST_LINE_ADDR: begin
        if (wr_done) begin
          state_d    = ST_FETCH;
          addr_d     = pos_q;
          fetch_ph_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          // Second fetch cycle: the memory byte is valid now
          data_d   = lcd_bus;
          state_d  = ST_CHAR;
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_data  = lcd_bus;
        end
      end
      ST_CHAR: begin
        if (wr_done) begin
          pos_d = pos_inc;
          if (pos_q == 5'd15) begin
            state_d  = ST_LINE_ADDR;
            wr_start = 1'b1;
            wr_data  = DDRAM_L2;
          end else if (pos_q == 5'd31) begin
            state_d      = ST_FRAME_END;
            frame_done_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            addr_d     = pos_inc;
            fetch_ph_d = 1'b0;
          end
        end
      end
      ST_FRAME_END: begin
        state_d  = ST_LINE_ADDR;
        wr_start = 1'b1;
        wr_data  = DDRAM_L1;
      end
      default: begin
        state_d = ST_POWERUP;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_POWERUP;
      pu_cnt_q     <= '0;
      idx_q        <= 3'd0;
      pos_q        <= 5'd0;
      addr_q       <= 5'd0;
      data_q       <= 8'h00;
      fetch_ph_q   <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pu_cnt_q     <= pu_cnt_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      fetch_ph_q   <= fetch_ph_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_write_seq #(
    .SETUP_CYC      (SETUP_CYC),
    .E_HIGH_CYC     (E_HIGH_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_write_seq (
    .clk_i       (CLK),
    .rst_i       (RST),
    .start_i     (wr_start),
    .rs_i        (wr_rs),
    .data_i      (wr_data),
    .long_wait_i (wr_long),
    .lcd_e_o     (LCD_E),
    .lcd_rs_o    (LCD_RS),
    .lcd_db_o    (LCD_DB),
    .done_o      (wr_done),
    .state_o     (wr_state)
  );

  assign ADDR       = addr_q;
  assign LCD_RW     = 1'b0;
  assign READY      = ready_q;
  assign FRAME_DONE = frame_done_q;

  assign dbg_o.top_state = state_q;
  assign dbg_o.wr_state  = wr_state;
  assign dbg_o.init_idx  = idx_q;
  assign dbg_o.pos       = pos_q;
  assign dbg_o.data      = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed self-checking bench for lcd_ctrl with short timing
// parameters and a registered 32-byte buffer-memory model.
module tb_lcd_ctrl;
  import lcd_pkg::*;

  localparam int unsigned P_PU  = 20;
  localparam int unsigned P_SU  = 1;
  localparam int unsigned P_EH  = 2;
  localparam int unsigned P_CW  = 5;
  localparam int unsigned P_CLR = 10;
  localparam int TX         = int'(P_SU + P_EH + P_CW);   // 8
  localparam int TX_CLR     = int'(P_SU + P_EH + P_CLR);  // 13
  localparam int FIRST_RISE = int'(P_PU + P_SU);          // 21
`ifdef LCD_CTRL_CURSOR_EN
  localparam logic [7:0] EXP_DISP = 8'h0F;
`else
  localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] addr;
  logic [7:0] lcd_bus, db;
  logic       rs, rw, e, ready, frame_done;
  lcd_dbg_t   dbg;

  lcd_ctrl #(
    .POWERUP_CYC    (P_PU),
    .SETUP_CYC      (P_SU),
    .E_HIGH_CYC     (P_EH),
    .CMD_WAIT_CYC   (P_CW),
    .CLEAR_WAIT_CYC (P_CLR)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .ADDR       (addr),
    .lcd_bus    (lcd_bus),
    .LCD_DB     (db),
    .LCD_RS     (rs),
    .LCD_RW     (rw),
    .LCD_E      (e),
    .READY      (ready),
    .FRAME_DONE (frame_done),
    .dbg_o      (dbg)
  );

  // registered buffer memory
  logic [7:0] mem [32];
  always @(posedge clk) lcd_bus <= mem[addr];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [13:0] obs_q[$];      // {ADDR, RS, DB} at each E rise
  int          obs_cyc_q[$];
  int          fd_cyc_q[$];
  int          fd_high = 0;
  int          ready_cyc = -1;
  logic        prev_e = 1'b0, prev_ready = 1'b0, prev_fd = 1'b0;
  logic [8:0]  rise_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (e && !prev_e) begin
        obs_q.push_back({addr, rs, db});
        obs_cyc_q.push_back(cyc);
        rise_val = {rs, db};
      end
      if (!e && prev_e) chk("db_hold", 32'({rs, db}), 32'(rise_val));
      if (frame_done) begin
        fd_high++;
        if (!prev_fd) fd_cyc_q.push_back(cyc);
      end
      if (ready && !prev_ready && ready_cyc < 0) ready_cyc = cyc;
    end
    prev_e     = e;
    prev_ready = ready;
    prev_fd    = frame_done;
  end

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int          exp_gap_q[$];  // expected E-rise spacing after each entry

  task automatic add_init();
    logic [7:0] cmds [6];
    cmds = '{8'h38, 8'h38, 8'h38, EXP_DISP, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({5'd0, 1'b0, cmds[i]});
      exp_gap_q.push_back((cmds[i] == 8'h01) ? TX_CLR : TX);
    end
  endtask

  task automatic add_frame(input string s, input logic [4:0] prev_addr);
    exp_q.push_back({prev_addr, 1'b0, 8'h80});
    exp_gap_q.push_back(TX + 2);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) begin
        exp_q.push_back({5'd15, 1'b0, 8'hC0});
        exp_gap_q.push_back(TX + 2);
      end
      exp_q.push_back({5'(k), 1'b1, s[k]});
      exp_gap_q.push_back((k == 15) ? TX : ((k == 31) ? TX + 1 : TX + 2));
    end
  endtask

  task automatic compare_writes(input string pfx, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_q.size())
        chk($sformatf("%s_wr%0d", pfx, i), 32'(obs_q[i]), 32'(exp_q[i]));
      if (i + 1 < obs_cyc_q.size())
        chk($sformatf("%s_gap%0d", pfx, i), 32'(obs_cyc_q[i+1] - obs_cyc_q[i]), 32'(exp_gap_q[i]));
    end
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(obs_q.size() >= n), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  string buf1, buf2;
  int    rel_cyc;
  int    k;
  bit    swapped;

  initial begin
    buf1 = " WORD Buffer!   -2nd line chars-";
    buf2 = "Hello, LCD world0123456789ABCDEF";
    for (int i = 0; i < 32; i++) mem[i] = buf1[i];

    // reset, then release and check the quiet power-up window
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({db, rs, rw, e, addr, ready, frame_done}), 32'd0);
    rst     = 1'b0;
    rel_cyc = cyc;
    for (int i = 0; i < int'(P_PU); i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("pu_quiet%0d", i), 32'({db, rs, rw, e, addr, ready, frame_done}), 32'd0);
    end
    @(negedge clk);
    chk("first_setup", 32'({e, rs, db}), 32'({1'b0, 1'b0, 8'h38}));

    // init + two frames; buffer contents change after the first frame
    swapped = 1'b0;
    k = 0;
    while (obs_q.size() < 75 && k < 3000) begin
      @(negedge clk);
      if (!swapped && fd_cyc_q.size() >= 1) begin
        for (int i = 0; i < 32; i++) mem[i] = buf2[i];
        swapped = 1'b1;
      end
      k++;
    end
    chk("two_frames_seen", 32'(obs_q.size() >= 75), 32'd1);
    add_init();
    add_frame(buf1, 5'd0);
    add_frame(buf2, 5'd31);
    compare_writes("run", 74);
    if (obs_cyc_q.size() >= 75) begin
      chk("first_rise", 32'(obs_cyc_q[0]), 32'(rel_cyc + FIRST_RISE));
      chk("ready_rise", 32'(ready_cyc), 32'(obs_cyc_q[6] - 1));
      chk("fd_count", 32'(fd_cyc_q.size()), 32'd2);
      chk("fd_width", 32'(fd_high), 32'd2);
      if (fd_cyc_q.size() >= 2) begin
        chk("fd_cyc0", 32'(fd_cyc_q[0]), 32'(obs_cyc_q[40] - 2));
        chk("fd_cyc1", 32'(fd_cyc_q[1]), 32'(obs_cyc_q[74] - 2));
      end
    end
    chk("ready_held", 32'(ready), 32'd1);
    chk("rw_low", 32'(rw), 32'd0);

    // reset while E is high during a data write
    k = 0;
    while (!(e && rs) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("found_data_e", 32'(e && rs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_e_drop", 32'(e), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_bus", 32'({addr, rs, db, frame_done}), 32'd0);
    chk("rst_state", 32'(dbg.top_state), 32'(ST_POWERUP));
    @(negedge clk);
    obs_q.delete();
    obs_cyc_q.delete();
    fd_cyc_q.delete();
    ready_cyc = -1;
    exp_q.delete();
    exp_gap_q.delete();
    rst     = 1'b0;
    rel_cyc = cyc;
    wait_writes("reinit_seen", 8, 400);
    add_init();
    exp_q.push_back({5'd0, 1'b0, 8'h80});
    exp_gap_q.push_back(TX + 2);
    compare_writes("reinit", 7);
    if (obs_cyc_q.size() >= 7) begin
      chk("reinit_first_rise", 32'(obs_cyc_q[0]), 32'(rel_cyc + FIRST_RISE));
      chk("reinit_ready", 32'(ready_cyc), 32'(obs_cyc_q[6] - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
